// File: rtl/mv_mult_seq.sv
// Matrix-vector multiply sequencer: loads NxN matrix + vector, drives external MAC row by row.
// Latency N+1 from last input to first result, N+2 per row; stalls in OUT until out_ready.
module mv_mult_seq #(
    parameter int N    = 2,
    parameter int W    = 4,
    parameter int ACCW = 2*W+$clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    output logic            mac_clr,
    output logic            mac_en,
    output logic [W-1:0]    mac_a,
    output logic [W-1:0]    mac_b,
    input  logic [ACCW-1:0] mac_acc,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    input  logic            out_ready,
    output logic            busy
);
    localparam int NE = N*N + N;
    localparam int AW = $clog2(NE);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_CAP, S_OUT} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   elem_cnt;
    logic [CW-1:0]   row, col;
    logic [W-1:0]    mem [NE];
    logic [AW-1:0]   a_idx, b_idx;
    logic            accept, last_elem, last_col, last_row;

    assign accept    = in_valid && in_ready;
    assign last_elem = (elem_cnt == AW'(NE-1));
    assign last_col  = (col == CW'(N-1));
    assign last_row  = (row == CW'(N-1));
    assign a_idx     = AW'(row) * AW'(N) + AW'(col);
    assign b_idx     = AW'(N*N) + AW'(col);

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && last_elem) state_nxt = S_CALC;
            end
            S_CALC: begin
                mac_en  = 1'b1;
                mac_clr = (col == '0);
                mac_a   = mem[a_idx];
                mac_b   = mem[b_idx];
                if (last_col) state_nxt = S_CAP;
            end
            S_CAP: state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready) state_nxt = last_row ? S_LOAD : S_CALC;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Storage is write-only from the stream; contents across reset are don't-care.
    always_ff @(posedge clk) begin
        if (accept) mem[elem_cnt] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt  <= '0;
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        elem_cnt <= last_elem ? '0 : elem_cnt + AW'(1);
                        row      <= '0;
                        col      <= '0;
                    end
                end
                S_CALC: col <= last_col ? '0 : col + CW'(1);
                S_CAP: begin
                    out_data  <= mac_acc;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        row       <= last_row ? '0 : row + CW'(1);
                        col       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
